// File: rtl/prog_freq_divider_if.sv
`default_nettype none
// ============================================================================
// Module  : prog_freq_divider_if
// Brief   : Control/status bundle for the programmable frequency divider.
// Revision: 1.0
// ============================================================================
interface prog_freq_divider_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             div_pend;
  logic             div_err;
  logic [CNT_W-1:0] div_active;
  logic             clk_out;
  logic             tick;

  modport master (
    output en, div_in, div_load,
    input  div_pend, div_err, div_active, clk_out, tick
  );

  modport slave (
    input  en, div_in, div_load,
    output div_pend, div_err, div_active, clk_out, tick
  );
endinterface
`default_nettype wire

// File: rtl/prog_freq_divider.sv
`default_nettype none
// ============================================================================
// Module  : prog_freq_divider
// Brief   : Runtime-reloadable divide-by-D enable generator, square wave + tick.
// Revision: 1.0
// ============================================================================
module prog_freq_divider #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  wire                      clk,
  input  wire                      rst,
  prog_freq_divider_if.slave       bus
);

  localparam logic [CNT_W-1:0] c_one      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_two      = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [CNT_W-1:0] c_rst_div  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] c_rst_cnt  = CNT_W'(DEFAULT_DIV - 1);

  generate
    if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** CNT_W) - 1) begin : g_bad_default
      $error("DEFAULT_DIV outside 2..2^CNT_W-1");
    end
  endgenerate

  // ceil(d/2) without forming d+1, which would carry out at d = 2^CNT_W-1
  function automatic logic [CNT_W-1:0] half_of(input logic [CNT_W-1:0] d);
    return (d >> 1) + {{(CNT_W-1){1'b0}}, d[0]};
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic w_wrap, w_load_ok, w_load_bad;

  assign w_wrap     = (cnt_q == act_q - c_one);
  assign w_load_ok  = bus.div_load && (bus.div_in >= c_two);
  assign w_load_bad = bus.div_load && (bus.div_in <  c_two);

  always_comb begin
    cnt_d      = cnt_q;
    act_d      = act_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    err_d      = w_load_bad;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;

    if (bus.en) begin
      if (w_wrap) begin
        // a load landing on the boundary wins over any older pending value
        if (w_load_ok)   act_d = bus.div_in;
        else if (pend_q) act_d = pend_val_q;
        pend_d = 1'b0;
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + c_one;
        if (w_load_ok) begin
          pend_val_d = bus.div_in;
          pend_d     = 1'b1;
        end
      end
      clk_out_d = (cnt_d < half_of(act_d));
    end else begin
      // idle switch: park at the last count so the next enabled edge starts a clean period
      if (pend_q) begin
        act_d     = pend_val_q;
        cnt_d     = pend_val_q - c_one;
        clk_out_d = 1'b0;
        pend_d    = 1'b0;
      end
      if (w_load_ok) begin
        pend_val_d = bus.div_in;
        pend_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= c_rst_cnt;
      act_q      <= c_rst_div;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.div_pend   = pend_q;
  assign bus.div_err    = err_q;
  assign bus.div_active = act_q;
  assign bus.clk_out    = clk_out_q;
  assign bus.tick       = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_freq_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_freq_divider
// Brief   : Directed-vector self-checking bench for prog_freq_divider.
// Revision: 1.0
// ============================================================================
module tb_prog_freq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  int   edge_no = 0;

  prog_freq_divider_if #(.CNT_W(8)) bus ();

  prog_freq_divider #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then check every output just after the edge.
  task automatic cyc(input logic r, input logic e, input logic ld, input logic [7:0] din,
                     input logic co, input logic tk, input logic [7:0] act,
                     input logic pd, input logic er);
    rst          = r;
    bus.en       = e;
    bus.div_load = ld;
    bus.div_in   = din;
    @(posedge clk);
    #1;
    edge_no++;
    check_eq($sformatf("e%0d clk_out", edge_no), {31'd0, bus.clk_out}, {31'd0, co});
    check_eq($sformatf("e%0d tick", edge_no), {31'd0, bus.tick}, {31'd0, tk});
    check_eq($sformatf("e%0d div_active", edge_no), {24'd0, bus.div_active}, {24'd0, act});
    check_eq($sformatf("e%0d div_pend", edge_no), {31'd0, bus.div_pend}, {31'd0, pd});
    check_eq($sformatf("e%0d div_err", edge_no), {31'd0, bus.div_err}, {31'd0, er});
  endtask

  initial begin
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = 8'd0;

    // reset state
    cyc(1,0,0,0,  0,0,4,0,0);
    cyc(1,0,0,0,  0,0,4,0,0);

    // default D=4: 1100 repeating, tick on first edge and every 4th
    for (int i = 0; i < 8; i++)
      cyc(0,1,0,0, (i % 4) < 2, (i % 4) == 0, 4,0,0);

    // mid-period load of 3: old period completes, then 110
    cyc(0,1,0,0,  1,1,4,0,0);
    cyc(0,1,0,0,  1,0,4,0,0);
    cyc(0,1,1,3,  0,0,4,1,0);
    cyc(0,1,0,0,  0,0,4,1,0);
    cyc(0,1,0,0,  1,1,3,0,0);
    cyc(0,1,0,0,  1,0,3,0,0);
    cyc(0,1,0,0,  0,0,3,0,0);
    cyc(0,1,0,0,  1,1,3,0,0);
    cyc(0,1,0,0,  1,0,3,0,0);
    cyc(0,1,0,0,  0,0,3,0,0);

    // illegal loads 1 and 0: error pulses only
    cyc(0,1,1,1,  1,1,3,0,1);
    cyc(0,1,0,0,  1,0,3,0,0);
    cyc(0,1,1,0,  0,0,3,0,1);
    cyc(0,1,0,0,  1,1,3,0,0);

    // switch to D=6, then freeze 5 cycles at cnt=2
    cyc(0,1,1,6,  1,0,3,1,0);
    cyc(0,1,0,0,  0,0,3,1,0);
    cyc(0,1,0,0,  1,1,6,0,0);
    cyc(0,1,0,0,  1,0,6,0,0);
    cyc(0,1,0,0,  1,0,6,0,0);
    for (int i = 0; i < 5; i++)
      cyc(0,0,0,0, 1,0,6,0,0);
    cyc(0,1,0,0,  0,0,6,0,0);
    cyc(0,1,0,0,  0,0,6,0,0);
    cyc(0,1,0,0,  0,0,6,0,0);
    cyc(0,1,0,0,  1,1,6,0,0);

    // load 255 then 2 while pending: only 2 lands
    cyc(0,1,1,255, 1,0,6,1,0);
    cyc(0,1,1,2,   1,0,6,1,0);
    cyc(0,1,0,0,   0,0,6,1,0);
    cyc(0,1,0,0,   0,0,6,1,0);
    cyc(0,1,0,0,   0,0,6,1,0);
    cyc(0,1,0,0,   1,1,2,0,0);
    cyc(0,1,0,0,   0,0,2,0,0);
    cyc(0,1,0,0,   1,1,2,0,0);
    cyc(0,1,0,0,   0,0,2,0,0);
    cyc(0,1,0,0,   1,1,2,0,0);

    // load on the wrap edge applies immediately
    cyc(0,1,0,0,  0,0,2,0,0);
    cyc(0,1,1,5,  1,1,5,0,0);
    cyc(0,1,0,0,  1,0,5,0,0);
    cyc(0,1,0,0,  1,0,5,0,0);
    cyc(0,1,0,0,  0,0,5,0,0);

    // pending applied while disabled, then clean restart with D=7
    cyc(0,0,1,7,  0,0,5,1,0);
    cyc(0,0,0,0,  0,0,7,0,0);
    cyc(0,1,0,0,  1,1,7,0,0);
    cyc(0,1,0,0,  1,0,7,0,0);
    cyc(0,1,0,0,  1,0,7,0,0);
    cyc(0,1,0,0,  1,0,7,0,0);
    cyc(0,1,0,0,  0,0,7,0,0);

    // reset mid-period with a pending load discards it
    cyc(0,1,1,3,  0,0,7,1,0);
    cyc(1,1,0,0,  0,0,4,0,0);
    cyc(0,1,0,0,  1,1,4,0,0);
    cyc(0,1,0,0,  1,0,4,0,0);
    cyc(0,1,0,0,  0,0,4,0,0);
    cyc(0,1,0,0,  0,0,4,0,0);
    cyc(0,1,0,0,  1,1,4,0,0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
